// File: rtl/parity_pkg.sv
// Shared receiver state encoding and serial line constants for the parity checker.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR,
      STOP
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator: clears on demand, folds in one bit per enabled cycle.
module parity_acc (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic bit_in,
   output logic par
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         par <= 1'b0;
      end else if (enable) begin
         par <= par ^ bit_in;
      end
   end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver (start, LSB-first payload, parity, stop) with parity/stop checks.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module serial_parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int   CNT_W   = $clog2(DATA_W + 1);
   localparam logic ODD_BIT = (ODD_PARITY != 0);

   rx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  count;
   logic              rx_par;
   logic              acc_par;
   logic              acc_clear;
   logic              acc_enable;
   logic              frame_perr;
   logic              frame_ferr;

   always_comb begin
      acc_clear  = 1'b0;
      acc_enable = 1'b0;
      if (bit_valid) begin
         acc_clear  = (state == IDLE) && (bit_in == START_BIT);
         acc_enable = (state == DATA);
      end
      frame_perr = acc_par ^ rx_par ^ ODD_BIT;
      frame_ferr = (bit_in != STOP_BIT);
   end

   parity_acc u_parity_acc (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .enable (acc_enable),
      .bit_in (bit_in),
      .par    (acc_par)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         count      <= '0;
         rx_par     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
         err_cnt    <= '0;
`endif
      end else begin
         data_valid <= 1'b0;
         if (bit_valid) begin
            case (state)
               IDLE: begin
                  if (bit_in == START_BIT) begin
                     state <= DATA;
                     count <= '0;
                  end
               end
               DATA: begin
                  // Shift-and-insert at the MSB keeps DATA_W=1 legal without a zero-width slice.
                  shreg <= (shreg >> 1) | (DATA_W'(bit_in) << (DATA_W - 1));
                  count <= count + 1'b1;
                  if (count == CNT_W'(DATA_W - 1)) begin
                     state <= PAR;
                  end
               end
               PAR: begin
                  rx_par <= bit_in;
                  state  <= STOP;
               end
               STOP: begin
                  data_out   <= shreg;
                  data_valid <= 1'b1;
                  parity_err <= frame_perr;
                  frame_err  <= frame_ferr;
`ifdef PARITY_ERR_CNT_EN
                  if ((frame_perr || frame_ferr) && (err_cnt != 8'hFF)) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
`endif
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomized and directed bench for serial_parity_checker (even and odd parity instances).
module tb_serial_parity_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       bit_valid;
   logic       bit_in;
   logic [7:0] data_e, data_o;
   logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0] ec_e, ec_o;
`endif

   int checks      = 0;
   int passes      = 0;
   int pulses_e    = 0;
   int exp_err_cnt = 0;

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) dut_even (
      .clk        (clk),
      .rst        (rst),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .data_out   (data_e),
      .data_valid (dv_e),
      .parity_err (pe_e),
      .frame_err  (fe_e)
`ifdef PARITY_ERR_CNT_EN
      ,
      .err_cnt    (ec_e)
`endif
   );

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) dut_odd (
      .clk        (clk),
      .rst        (rst),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .data_out   (data_o),
      .data_valid (dv_o),
      .parity_err (pe_o),
      .frame_err  (fe_o)
`ifdef PARITY_ERR_CNT_EN
      ,
      .err_cnt    (ec_o)
`endif
   );

   always @(negedge clk) begin
      if (dv_e) pulses_e++;
   end

   // Parity error means the total count of ones (payload + parity bit + odd flag) is odd.
   function automatic logic exp_perr(input logic [7:0] d, input logic p, input int odd);
      return ((($countones(d) + int'(p) + odd) % 2) != 0);
   endfunction

   task automatic send_bit(input logic b, input int stall);
      for (int k = 0; k < stall; k++) begin
         bit_valid = 1'b0;
         bit_in    = $urandom_range(0, 1);
         @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      bit_in    = b;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int stall);
      send_bit(1'b0, stall);
      for (int i = 0; i < 8; i++) send_bit(d[i], stall);
      send_bit(p, stall);
      send_bit(s, stall);
      if ((exp_perr(d, p, 0) || !s) && exp_err_cnt < 255) exp_err_cnt++;
   endtask

   task automatic idle(input int n, input logic line_level);
      for (int k = 0; k < n; k++) begin
         bit_valid = line_level;
         bit_in    = 1'b1;
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data_e !== 8'h00) $display("FAIL reset_data actual=%h required=00", data_e); else passes++;
      checks++; if (dv_e !== 1'b0) $display("FAIL reset_dv actual=%b required=0", dv_e); else passes++;
      checks++; if (pe_e !== 1'b0 || fe_e !== 1'b0) $display("FAIL reset_flags actual=%b%b required=00", pe_e, fe_e); else passes++;
`ifdef PARITY_ERR_CNT_EN
      checks++; if (ec_e !== 8'd0) $display("FAIL reset_errcnt actual=%0d required=0", ec_e); else passes++;
`endif
      rst = 1'b0; bit_valid = 1'b0;
      exp_err_cnt = 0;
      idle(2, 1'b0);
   endtask

   task automatic test_basic();
      int p0;
      p0 = pulses_e;
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      checks++; if (data_e !== 8'hA5) $display("FAIL basic_data actual=%h required=a5", data_e); else passes++;
      checks++; if (dv_e !== 1'b1) $display("FAIL basic_dv actual=%b required=1", dv_e); else passes++;
      checks++; if (pe_e !== 1'b0 || fe_e !== 1'b0) $display("FAIL basic_flags actual=%b%b required=00", pe_e, fe_e); else passes++;
      idle(1, 1'b0);
      checks++; if (dv_e !== 1'b0) $display("FAIL basic_dv_drop actual=%b required=0", dv_e); else passes++;
      checks++; if (pulses_e !== p0 + 1) $display("FAIL basic_pulses actual=%0d required=%0d", pulses_e, p0 + 1); else passes++;
      checks++; if (data_e !== 8'hA5) $display("FAIL basic_hold actual=%h required=a5", data_e); else passes++;
   endtask

   task automatic test_parity_err();
      send_frame(8'h07, 1'b0, 1'b1, 0);
      checks++; if (data_e !== 8'h07) $display("FAIL perr_data actual=%h required=07", data_e); else passes++;
      checks++; if (pe_e !== 1'b1 || fe_e !== 1'b0) $display("FAIL perr_flags actual=%b%b required=10", pe_e, fe_e); else passes++;
`ifdef PARITY_ERR_CNT_EN
      checks++; if (ec_e !== 8'(exp_err_cnt)) $display("FAIL perr_errcnt actual=%0d required=%0d", ec_e, exp_err_cnt); else passes++;
`endif
      idle(3, 1'b1);
      checks++; if (pe_e !== 1'b1) $display("FAIL perr_hold actual=%b required=1", pe_e); else passes++;
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pulses_e;
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      checks++; if (fe_e !== 1'b1 || pe_e !== 1'b0) $display("FAIL b2b_first_flags actual=%b%b required=01", pe_e, fe_e); else passes++;
      checks++; if (data_e !== 8'h3C) $display("FAIL b2b_first_data actual=%h required=3c", data_e); else passes++;
      send_frame(8'h01, 1'b1, 1'b1, 0);
      checks++; if (data_e !== 8'h01) $display("FAIL b2b_second_data actual=%h required=01", data_e); else passes++;
      checks++; if (dv_e !== 1'b1 || pe_e !== 1'b0 || fe_e !== 1'b0) $display("FAIL b2b_second_flags actual=%b%b%b required=100", dv_e, pe_e, fe_e); else passes++;
      idle(1, 1'b0);
      checks++; if (pulses_e !== p0 + 2) $display("FAIL b2b_pulses actual=%0d required=%0d", pulses_e, p0 + 2); else passes++;
   endtask

   task automatic test_stall();
      send_frame(8'h5A, 1'b0, 1'b1, 3);
      checks++; if (data_e !== 8'h5A) $display("FAIL stall_data actual=%h required=5a", data_e); else passes++;
      checks++; if (dv_e !== 1'b1 || pe_e !== 1'b0 || fe_e !== 1'b0) $display("FAIL stall_flags actual=%b%b%b required=100", dv_e, pe_e, fe_e); else passes++;
      idle(1, 1'b0);
   endtask

   task automatic test_reset_midframe();
      int p0;
      p0 = pulses_e;
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_err_cnt = 0;
      checks++; if (dv_e !== 1'b0 || data_e !== 8'h00) $display("FAIL midrst_state actual=%b/%h required=0/00", dv_e, data_e); else passes++;
      send_frame(8'h81, 1'b0, 1'b1, 0);
      checks++; if (data_e !== 8'h81 || pe_e !== 1'b0 || fe_e !== 1'b0) $display("FAIL midrst_frame actual=%h/%b%b required=81/00", data_e, pe_e, fe_e); else passes++;
      idle(1, 1'b0);
      checks++; if (pulses_e !== p0 + 1) $display("FAIL midrst_pulses actual=%0d required=%0d", pulses_e, p0 + 1); else passes++;
`ifdef PARITY_ERR_CNT_EN
      checks++; if (ec_e !== 8'd0) $display("FAIL midrst_errcnt actual=%0d required=0", ec_e); else passes++;
`endif
   endtask

   task automatic test_odd_parity();
      send_frame(8'h00, 1'b1, 1'b1, 0);
      checks++; if (pe_o !== 1'b0) $display("FAIL odd_good actual=%b required=0", pe_o); else passes++;
      checks++; if (pe_e !== 1'b1) $display("FAIL odd_even_view actual=%b required=1", pe_e); else passes++;
      send_frame(8'h00, 1'b0, 1'b1, 0);
      checks++; if (pe_o !== 1'b1) $display("FAIL odd_bad actual=%b required=1", pe_o); else passes++;
      checks++; if (data_o !== 8'h00 || dv_o !== 1'b1) $display("FAIL odd_data actual=%h/%b required=00/1", data_o, dv_o); else passes++;
      idle(1, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       p, s;
      int         p0;
      for (int n = 0; n < 40; n++) begin
         d = 8'($urandom);
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) != 0);
         idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
         p0 = pulses_e;
         send_frame(d, p, s, $urandom_range(0, 2));
         checks++; if (data_e !== d) $display("FAIL rand_data n=%0d actual=%h required=%h", n, data_e, d); else passes++;
         checks++; if (pe_e !== exp_perr(d, p, 0)) $display("FAIL rand_perr_even n=%0d actual=%b required=%b", n, pe_e, exp_perr(d, p, 0)); else passes++;
         checks++; if (pe_o !== exp_perr(d, p, 1)) $display("FAIL rand_perr_odd n=%0d actual=%b required=%b", n, pe_o, exp_perr(d, p, 1)); else passes++;
         checks++; if (fe_e !== !s) $display("FAIL rand_ferr n=%0d actual=%b required=%b", n, fe_e, !s); else passes++;
         checks++; if (dv_e !== 1'b1) $display("FAIL rand_dv n=%0d actual=%b required=1", n, dv_e); else passes++;
`ifdef PARITY_ERR_CNT_EN
         checks++; if (ec_e !== 8'(exp_err_cnt)) $display("FAIL rand_errcnt n=%0d actual=%0d required=%0d", n, ec_e, exp_err_cnt); else passes++;
`endif
         idle(1, 1'b0);
         checks++; if (pulses_e !== p0 + 1) $display("FAIL rand_pulses n=%0d actual=%0d required=%0d", n, pulses_e, p0 + 1); else passes++;
      end
   endtask

   initial begin
      rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b1;
      test_reset();
      test_basic();
      test_parity_err();
      test_back_to_back();
      test_stall();
      test_reset_midframe();
      test_odd_parity();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
